// File: rtl/bls_dispatch_ctrl.sv
// Round-robin start/serve controller for a bank of Black-Scholes pricing engines.
// Optional per-engine hang watchdog is built when BLS_WATCHDOG_EN is defined.
module bls_dispatch_ctrl #(
    parameter int BSMODS  = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              startSystem,
    input  logic              OutOfData,
    input  logic [BSMODS-1:0] BS_READY,
    input  logic [BSMODS-1:0] BS_DONE,
    input  logic [BSMODS-1:0] BS_IDLE,
    input  logic [BSMODS-1:0] hasUnusedData,
    input  logic              serve_ack,
    output logic [BSMODS-1:0] BS_START,
    output logic [BSMODS-1:0] SERVE_REG,
    output logic [7:0]        LED,
    output logic [CNT_W-1:0]  done_count,
    output logic              busy
);

    localparam int PTR_W = (BSMODS > 1) ? $clog2(BSMODS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   start_ptr_reg, start_ptr_next;
    logic [PTR_W-1:0]   serve_ptr_reg, serve_ptr_next;
    logic [PTR_W-1:0]   serve_idx_reg, serve_idx_next;
    logic [BSMODS-1:0]  inflight_reg, inflight_next;
    logic [BSMODS-1:0]  start_reg, start_next;
    logic [BSMODS-1:0]  serve_reg, serve_next;
    logic [CNT_W-1:0]   done_count_reg, done_count_next;
    logic               ood_seen_reg, ood_seen_next;
    logic               wd_fault_reg, wd_fault_next;

    logic [BSMODS-1:0]  eligible;
    logic [BSMODS-1:0]  candidates;
    logic [BSMODS-1:0]  start_set;
    logic [BSMODS-1:0]  serve_clr;
    logic [BSMODS-1:0]  wd_hit;
    logic               start_found, serve_found;
    logic [PTR_W-1:0]   start_idx, serve_idx;
    logic               active;

    // First set bit at or after ptr, wrapping; returns {found, index}.
    function automatic logic [PTR_W:0] pick_first(input logic [BSMODS-1:0] vec,
                                                  input logic [PTR_W-1:0]  ptr);
        logic [PTR_W:0]   pos;
        logic             found;
        logic [PTR_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < BSMODS; k++) begin
            pos = {1'b0, ptr} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(BSMODS))
                pos = pos - (PTR_W+1)'(BSMODS);
            if (!found && vec[pos[PTR_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[PTR_W-1:0];
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(BSMODS-1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [BSMODS-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [BSMODS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

`ifdef BLS_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    // Hit fires on the edge the counter would reach TIMEOUT, releasing the engine.
    generate
        for (genvar gi = 0; gi < BSMODS; gi++) begin : g_wd
            logic [WD_W-1:0] wd_cnt_reg;

            assign wd_hit[gi] = inflight_reg[gi] & ~BS_DONE[gi] &
                                (wd_cnt_reg == WD_W'(TIMEOUT - 1));

            always_ff @(posedge clock) begin
                if (!reset)
                    wd_cnt_reg <= '0;
                else if (start_set[gi] || wd_hit[gi])
                    wd_cnt_reg <= '0;
                else if (inflight_reg[gi] && !BS_DONE[gi])
                    wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
        end
    endgenerate
`else
    assign wd_hit = '0;
`endif

    assign eligible   = BS_READY & BS_IDLE & hasUnusedData & ~inflight_reg;
    assign candidates = BS_DONE & inflight_reg;
    assign active     = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign {start_found, start_idx} = pick_first(eligible, start_ptr_reg);
    assign {serve_found, serve_idx} = pick_first(candidates, serve_ptr_reg);

    always_comb begin
        state_next      = state_reg;
        start_ptr_next  = start_ptr_reg;
        serve_ptr_next  = serve_ptr_reg;
        serve_idx_next  = serve_idx_reg;
        start_next      = '0;
        serve_next      = serve_reg;
        done_count_next = done_count_reg;
        ood_seen_next   = ood_seen_reg;
        wd_fault_next   = wd_fault_reg | (|wd_hit);
        start_set       = '0;
        serve_clr       = '0;

        case (state_reg)
            ST_IDLE, ST_FINISH: begin
                if (startSystem) begin
                    state_next      = ST_RUN;
                    done_count_next = '0;
                    ood_seen_next   = 1'b0;
                    wd_fault_next   = 1'b0;
                end
            end
            ST_RUN: begin
                if (start_found) begin
                    start_next     = onehot(start_idx);
                    start_set      = onehot(start_idx);
                    start_ptr_next = ptr_inc(start_idx);
                end
                if (OutOfData)
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (inflight_reg == '0 && serve_reg == '0)
                    state_next = ST_FINISH;
            end
            default: state_next = ST_IDLE;
        endcase

        if (active && OutOfData)
            ood_seen_next = 1'b1;

        // Serve path: hold until ack, then one idle cycle before the next pick.
        if (active) begin
            if (serve_reg != '0) begin
                if (serve_ack) begin
                    serve_next     = '0;
                    serve_clr      = serve_reg;
                    serve_ptr_next = ptr_inc(serve_idx_reg);
                    if (done_count_reg != '1)
                        done_count_next = done_count_reg + 1'b1;
                end
            end else if (serve_found) begin
                serve_next     = onehot(serve_idx);
                serve_idx_next = serve_idx;
            end
        end

        inflight_next = (inflight_reg | start_set) & ~serve_clr & ~wd_hit;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            start_ptr_reg  <= '0;
            serve_ptr_reg  <= '0;
            serve_idx_reg  <= '0;
            inflight_reg   <= '0;
            start_reg      <= '0;
            serve_reg      <= '0;
            done_count_reg <= '0;
            ood_seen_reg   <= 1'b0;
            wd_fault_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_ptr_reg  <= start_ptr_next;
            serve_ptr_reg  <= serve_ptr_next;
            serve_idx_reg  <= serve_idx_next;
            inflight_reg   <= inflight_next;
            start_reg      <= start_next;
            serve_reg      <= serve_next;
            done_count_reg <= done_count_next;
            ood_seen_reg   <= ood_seen_next;
            wd_fault_reg   <= wd_fault_next;
        end
    end

    assign BS_START   = start_reg;
    assign SERVE_REG  = serve_reg;
    assign done_count = done_count_reg;
    assign busy       = active;
    assign LED        = {done_count_reg[2:0], wd_fault_reg, ood_seen_reg,
                         |inflight_reg, 2'(state_reg)};

endmodule

// File: tb/tb_bls_dispatch_ctrl.sv
// Directed bench for bls_dispatch_ctrl: reset, round-robin starts, serve order,
// pointer wrap, drain/finish, mid-serve reset and hung-engine behaviour.
module tb_bls_dispatch_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        startSystem;
    logic        OutOfData;
    logic [3:0]  BS_READY;
    logic [3:0]  BS_DONE;
    logic [3:0]  BS_IDLE;
    logic [3:0]  hasUnusedData;
    logic        serve_ack;
    logic [3:0]  BS_START;
    logic [3:0]  SERVE_REG;
    logic [7:0]  LED;
    logic [15:0] done_count;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    bls_dispatch_ctrl #(.BSMODS(4), .CNT_W(16), .TIMEOUT(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .startSystem   (startSystem),
        .OutOfData     (OutOfData),
        .BS_READY      (BS_READY),
        .BS_DONE       (BS_DONE),
        .BS_IDLE       (BS_IDLE),
        .hasUnusedData (hasUnusedData),
        .serve_ack     (serve_ack),
        .BS_START      (BS_START),
        .SERVE_REG     (SERVE_REG),
        .LED           (LED),
        .done_count    (done_count),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a done vector, expect the selected engine, ack it, expect release.
    task automatic serve_one(input logic [3:0] done_vec, input logic [3:0] exp_sel,
                             input string tag);
        BS_DONE = done_vec;
        tick();
        check({tag, " sel"}, 32'(SERVE_REG), 32'(exp_sel));
        serve_ack = 1'b1;
        tick();
        serve_ack = 1'b0;
        BS_DONE   = BS_DONE & ~exp_sel;
        check({tag, " rel"}, 32'(SERVE_REG), 32'h0);
    endtask

    initial begin
        reset = 1'b0; startSystem = 1'b0; OutOfData = 1'b0; serve_ack = 1'b0;
        BS_READY = '0; BS_DONE = '0; BS_IDLE = '0; hasUnusedData = '0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            startSystem   = 1'($urandom);
            OutOfData     = 1'($urandom);
            serve_ack     = 1'($urandom);
            BS_READY      = 4'($urandom);
            BS_DONE       = 4'($urandom);
            BS_IDLE       = 4'($urandom);
            hasUnusedData = 4'($urandom);
            tick();
        end
        check("rst BS_START", 32'(BS_START), 32'h0);
        check("rst SERVE_REG", 32'(SERVE_REG), 32'h0);
        check("rst LED", 32'(LED), 32'h00);
        check("rst done_count", 32'(done_count), 32'h0);
        check("rst busy", 32'(busy), 32'h0);

        startSystem = 1'b0; OutOfData = 1'b0; serve_ack = 1'b0;
        BS_READY = '0; BS_DONE = '0; BS_IDLE = 4'b1111; hasUnusedData = 4'b1111;
        reset = 1'b1;
        tick();
        check("idle state", 32'(LED[1:0]), 32'd0);

        // Round-robin starts
        startSystem = 1'b1;
        BS_READY    = 4'b1111;
        tick();
        startSystem = 1'b0;
        check("run busy", 32'(busy), 32'h1);
        check("run state", 32'(LED[1:0]), 32'd1);
        check("rr start0", 32'(BS_START), 32'h0);
        tick(); check("rr 0001", 32'(BS_START), 32'b0001);
        tick(); check("rr 0010", 32'(BS_START), 32'b0010);
        tick(); check("rr 0100", 32'(BS_START), 32'b0100);
        tick(); check("rr 1000", 32'(BS_START), 32'b1000);
        BS_READY = '0;
        tick(); check("rr 0000", 32'(BS_START), 32'b0000);
        check("inflight led", 32'(LED[2]), 32'h1);

        // Serve ordering: engines 1 and 3 done
        serve_one(4'b1010, 4'b0010, "serve e1");
        check("done after e1", 32'(done_count), 32'd1);
        serve_one(4'b1000, 4'b1000, "serve e3");
        check("done after e3", 32'(done_count), 32'd2);
        check("led done bits", 32'(LED[7:5]), 32'd2);

        // Stray ack with nothing served, and done from a non-inflight engine
        serve_ack = 1'b1;
        BS_DONE   = 4'b0010;
        tick();
        serve_ack = 1'b0;
        BS_DONE   = '0;
        check("stray ack count", 32'(done_count), 32'd2);
        check("stray done sel", 32'(SERVE_REG), 32'h0);

        // Pointer wrap: serve 2, restart 2 so start_ptr=3, then serve 0 across wrap
        serve_one(4'b0100, 4'b0100, "serve e2");
        BS_READY = 4'b0100;
        tick(); check("start e2", 32'(BS_START), 32'b0100);
        BS_READY = '0;
        serve_one(4'b0001, 4'b0001, "serve wrap e0");
        check("done after wrap", 32'(done_count), 32'd4);
        BS_READY = 4'b0001;
        tick(); check("start wrap e0", 32'(BS_START), 32'b0001);
        BS_READY = 4'b1010;
        tick(); check("start ptr1 e1", 32'(BS_START), 32'b0010);
        BS_READY = '0;
        tick(); check("start idle", 32'(BS_START), 32'b0000);

        // Inflight now {0,1,2}; serve engine 1, leaving {0,2}
        serve_one(4'b0010, 4'b0010, "serve e1b");

        // Drain: the start picked on the OutOfData cycle still issues
        OutOfData = 1'b1;
        BS_READY  = 4'b1111;
        tick();
        check("drain last start", 32'(BS_START), 32'b1000);
        check("drain state", 32'(LED[1:0]), 32'd2);
        tick();
        check("drain no start", 32'(BS_START), 32'b0000);
        tick();
        check("drain no start2", 32'(BS_START), 32'b0000);
        BS_READY = '0;
        serve_one(4'b1101, 4'b0100, "drain e2");
        serve_one(4'b1001, 4'b1000, "drain e3");
        serve_one(4'b0001, 4'b0001, "drain e0");
        check("drain done", 32'(done_count), 32'd8);
        tick();
        check("finish state", 32'(LED[1:0]), 32'd3);
        check("finish busy", 32'(busy), 32'h0);
        check("finish ood led", 32'(LED[3]), 32'h1);
        check("finish inflight", 32'(LED[2]), 32'h0);

        // Restart from FINISH, then reset mid-serve
        startSystem = 1'b1;
        OutOfData   = 1'b0;
        tick();
        startSystem = 1'b0;
        check("restart LED", 32'(LED), 32'h01);
        check("restart count", 32'(done_count), 32'd0);
        BS_READY = 4'b0001;
        tick(); check("restart start", 32'(BS_START), 32'b0001);
        BS_READY = '0;
        BS_DONE  = 4'b0001;
        tick(); check("midserve sel", 32'(SERVE_REG), 32'b0001);
        reset = 1'b0;
        tick();
        check("midrst SERVE_REG", 32'(SERVE_REG), 32'h0);
        check("midrst BS_START", 32'(BS_START), 32'h0);
        check("midrst LED", 32'(LED), 32'h00);
        check("midrst busy", 32'(busy), 32'h0);
        BS_DONE = '0;
        reset   = 1'b1;
        tick();

        // Hung engine 2
        startSystem = 1'b1;
        tick();
        startSystem = 1'b0;
        BS_READY    = 4'b0100;
        tick();
        check("hang start", 32'(BS_START), 32'b0100);
        BS_READY  = '0;
        OutOfData = 1'b1;
`ifdef BLS_WATCHDOG_EN
        for (int i = 0; i < 15; i++) tick();
        check("wd before", 32'(LED[2]), 32'h1);
        tick();
        check("wd inflight", 32'(LED[2]), 32'h0);
        check("wd fault", 32'(LED[4]), 32'h1);
        tick();
        check("wd finish", 32'(LED[1:0]), 32'd3);
        check("wd count", 32'(done_count), 32'd0);
`else
        for (int i = 0; i < 40; i++) tick();
        check("hang drain", 32'(LED[1:0]), 32'd2);
        check("hang inflight", 32'(LED[2]), 32'h1);
        check("hang no fault", 32'(LED[4]), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
